// File: rtl/fnd_time_display.sv
// -----------------------------------------------------------------------------
// fnd_time_display
//   Drives a 4-digit common-anode 7-segment display from the watch time bus.
//   At every frame boundary one pair of binary bytes is captured: {hour,min}
//   or {min,sec}. Both bytes go through a sequential double-dabble in parallel,
//   taking 8 cycles. The BCD result is then loaded into the display digit
//   registers in one step. Digits are scanned right to left, each for SCAN_DIV
//   clocks.
//
// Ports
//   clk        rising-edge system clock
//   reset_n    asynchronous active-low reset
//   hour/min/sec  8-bit binary time from the watch core
//   disp_mode  0: HH.MM, 1: MM.SS (sampled at frame snapshot)
//   blank      1: all digits dark (counters keep running)
//   seg_n      active-low segments {dp,g,f,e,d,c,b,a}
//   com_n      active-low digit enables, bit3 = leftmost digit
//   conv_busy  high while the BCD conversion is shifting
// -----------------------------------------------------------------------------
module fnd_time_display #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       disp_mode,
  input  logic       blank,
  output logic [7:0] seg_n,
  output logic [3:0] com_n,
  output logic       conv_busy
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int n = 0; n < 3; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Segment pattern {g..a}, active-low; dash overrides the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic dash);
    logic [6:0] s;
    if (dash) begin
      s = 7'b0111111;
    end else begin
      case (d)
        4'd0:    s = 7'h40;
        4'd1:    s = 7'h79;
        4'd2:    s = 7'h24;
        4'd3:    s = 7'h30;
        4'd4:    s = 7'h19;
        4'd5:    s = 7'h12;
        4'd6:    s = 7'h02;
        4'd7:    s = 7'h78;
        4'd8:    s = 7'h00;
        4'd9:    s = 7'h10;
        default: s = 7'h7F;
      endcase
    end
    return s;
  endfunction

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_digit_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;
  logic               r_first;
  logic               r_busy;
  logic [2:0]         r_step;
  logic [3:0][3:0]    r_dig;       // [3]=hi tens .. [0]=lo ones
  logic [1:0]         r_dash;      // [1]=hi byte, [0]=lo byte
  logic               r_disp_mode;
  logic [7:0]         r_seg_n;
  logic [3:0]         r_com_n;

  logic [19:0]        r_sr_hi_p0;
  logic [19:0]        r_sr_lo_p0;
  logic               r_snap_mode_p0;

  logic               w_scan_wrap;
  logic               w_snap;
  logic [19:0]        w_hi_nxt;
  logic [19:0]        w_lo_nxt;
  logic [3:0]         w_cur_dig;
  logic               w_cur_dash;
  logic               w_dp_n;

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_snap      = r_first || (w_scan_wrap && (r_digit_idx == 2'd3));
  assign w_hi_nxt    = dd_step(r_sr_hi_p0);
  assign w_lo_nxt    = dd_step(r_sr_lo_p0);
  assign w_cur_dig   = r_dig[r_digit_idx];
  assign w_cur_dash  = r_digit_idx[1] ? r_dash[1] : r_dash[0];
  // dp only on digit 2: steady in MM.SS, blinking in HH.MM.
  assign w_dp_n      = !((r_digit_idx == 2'd2) && (r_disp_mode || !r_blink));

  // Stage p0: snapshot capture and shift registers (pure data, no reset)
  always_ff @(posedge clk) begin
    if (w_snap) begin
      r_sr_hi_p0     <= {12'd0, disp_mode ? min : hour};
      r_sr_lo_p0     <= {12'd0, disp_mode ? sec : min};
      r_snap_mode_p0 <= disp_mode;
    end else if (r_busy) begin
      r_sr_hi_p0     <= w_hi_nxt;
      r_sr_lo_p0     <= w_lo_nxt;
    end
  end

  // Stage p1: scan/blink control, display registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_first     <= 1'b1;
      r_busy      <= 1'b0;
      r_step      <= 3'd0;
      r_dig       <= '0;
      r_dash      <= 2'b00;
      r_disp_mode <= 1'b0;
      r_seg_n     <= 8'hFF;
      r_com_n     <= 4'hF;
    end else begin
      r_first <= 1'b0;

      if (w_scan_wrap) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
      end

      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end

      if (w_snap) begin
        r_busy <= 1'b1;
        r_step <= 3'd0;
      end else if (r_busy) begin
        r_step <= r_step + 3'd1;
        if (r_step == 3'd7) begin
          // Last shift: load all four digits together so no frame is torn.
          // A non-zero hundreds nibble means the byte exceeded 99.
          r_busy      <= 1'b0;
          r_dig[3]    <= w_hi_nxt[15:12];
          r_dig[2]    <= w_hi_nxt[11:8];
          r_dig[1]    <= w_lo_nxt[15:12];
          r_dig[0]    <= w_lo_nxt[11:8];
          r_dash      <= {(w_hi_nxt[19:16] != 4'd0), (w_lo_nxt[19:16] != 4'd0)};
          r_disp_mode <= r_snap_mode_p0;
        end
      end

      if (blank) begin
        r_seg_n <= 8'hFF;
        r_com_n <= 4'hF;
      end else begin
        r_seg_n <= {w_dp_n, seg7(w_cur_dig, w_cur_dash)};
        r_com_n <= ~(4'b0001 << r_digit_idx);
      end
    end
  end

  assign seg_n     = r_seg_n;
  assign com_n     = r_com_n;
  assign conv_busy = r_busy;

endmodule

// File: tb/tb_fnd_time_display.sv
module tb_fnd_time_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 64;
  localparam int FRAME = 4 * SCAN;

  logic       clk = 1'b0;
  logic       t_rst_n;
  logic [7:0] t_hour, t_min, t_sec;
  logic       t_mode, t_blank;
  logic [7:0] seg_n;
  logic [3:0] com_n;
  logic       conv_busy;

  always #5 clk = ~clk;

  fnd_time_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk       (clk),
    .reset_n   (t_rst_n),
    .hour      (t_hour),
    .min       (t_min),
    .sec       (t_sec),
    .disp_mode (t_mode),
    .blank     (t_blank),
    .seg_n     (seg_n),
    .com_n     (com_n),
    .conv_busy (conv_busy)
  );

  typedef struct {
    int k;
    int hi;
    int lo;
    bit mode;
  } snap_t;

  snap_t q[$];
  int    k;          // clock edges since reset release
  int    last_snap;  // edge number of most recent snapshot (0 = none)
  logic  blank_s;
  int    checks;
  int    errors;

  function automatic logic [7:0] code(input int n);
    case (n)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Reference: everything derives from the edge count and the snapshot list.
  task automatic check_outputs();
    snap_t      cur;
    int         d, ph, v;
    logic [7:0] es;
    logic [3:0] ec;
    logic       eb;
    cur = '{k: 0, hi: 0, lo: 0, mode: 1'b0};
    while (q.size() > 2 && q[1].k <= k - 9) q.delete(0);
    foreach (q[i]) if (q[i].k <= k - 9) cur = q[i];
    eb = (last_snap > 0) && (k - last_snap <= 7);
    if (blank_s) begin
      es = 8'hFF;
      ec = 4'hF;
    end else begin
      d  = ((k - 1) / SCAN) % 4;
      ph = ((k - 1) / BLINK) % 2;
      v  = (d >= 2) ? cur.hi : cur.lo;
      if (v > 99) es = 8'hBF;
      else        es = code((d % 2 == 1) ? v / 10 : v % 10);
      if (d == 2 && (cur.mode || ph == 0)) es[7] = 1'b0;
      ec = ~(4'b0001 << d);
    end
    chk("seg_n", seg_n, es);
    chk("com_n", {4'h0, com_n}, {4'h0, ec});
    chk("conv_busy", {7'd0, conv_busy}, {7'd0, eb});
  endtask

  task automatic step();
    snap_t s;
    @(posedge clk);
    k++;
    blank_s = t_blank;
    if (k == 1 || k % FRAME == 0) begin
      s.k    = k;
      s.hi   = t_mode ? int'(t_min) : int'(t_hour);
      s.lo   = t_mode ? int'(t_sec) : int'(t_min);
      s.mode = t_mode;
      q.push_back(s);
      last_snap = k;
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, seg_n, 8'hFF);
    chk({tag, "_com"}, {4'h0, com_n}, 8'h0F);
    chk({tag, "_busy"}, {7'd0, conv_busy}, 8'h00);
  endtask

  task automatic release_reset();
    @(negedge clk);
    t_rst_n   = 1'b1;
    k         = 0;
    last_snap = 0;
    q.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    k       = 0;
    last_snap = 0;
    t_rst_n = 1'b0;
    t_hour  = 8'd12;
    t_min   = 8'd34;
    t_sec   = 8'd0;
    t_mode  = 1'b0;
    t_blank = 1'b0;

    // Power-on reset for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // HH.MM 12:34, long enough to see the dp blink phase change
    repeat (140) step();

    // MM.SS 59:07, steady dp
    t_mode = 1'b1; t_min = 8'd59; t_sec = 8'd7;
    repeat (48) step();

    // Hour out of range shows dashes
    t_mode = 1'b0; t_hour = 8'd150; t_min = 8'd0;
    repeat (48) step();

    // Mid-frame minute change must wait for the next snapshot
    t_hour = 8'd12; t_min = 8'd34;
    repeat (40) step();
    for (int i = 0; i < FRAME && ((k / SCAN) % 4) != 1; i++) step();
    t_min = 8'd35;
    repeat (48) step();

    // Blank for 10 cycles, counters keep running
    t_blank = 1'b1;
    repeat (10) step();
    t_blank = 1'b0;
    repeat (24) step();

    // Async reset while a conversion is in flight
    t_min = 8'd47;
    for (int i = 0; i < 2 * FRAME && !(last_snap > 1 && k - last_snap == 3); i++) step();
    chk("busy_before_abort", {7'd0, conv_busy}, 8'h01);
    #2;
    t_rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("abort_hold");
    t_hour = 8'd9; t_min = 8'd5;
    release_reset();
    repeat (48) step();

    // Randomised traffic, including out-of-range bytes and blank pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        t_hour = 8'($urandom_range(0, 255));
        t_min  = 8'($urandom_range(0, 255));
        t_sec  = 8'($urandom_range(0, 255));
        t_mode = 1'($urandom_range(0, 1));
      end
      t_blank = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
